// File: rtl/clkdiv_pkg.sv
// Shared encodings for the programmable clock divider and its receive-side ratio detector.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_DIV2  = 2'b00;
  localparam logic [1:0] SEL_DIV4  = 2'b01;
  localparam logic [1:0] SEL_DIV8  = 2'b10;
  localparam logic [1:0] SEL_DIV16 = 2'b11;

  localparam int unsigned PERIOD_DIV2  = 2;
  localparam int unsigned PERIOD_DIV4  = 4;
  localparam int unsigned PERIOD_DIV8  = 8;
  localparam int unsigned PERIOD_DIV16 = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a delay flop for edge detection.
module edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic r_s0;
  logic r_s1;
  logic r_s2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s0 <= async_in;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  assign sync_out = r_s1;
  assign rise     = r_s1 & ~r_s2;
  assign fall     = ~r_s1 & r_s2;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures period/high time of a divided clock and recovers its /2../16 ratio with lock tracking.
module clock_ratio_detector
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clock_div,
  output logic [1:0]       Sel_det,
  output logic             Locked,
  output logic             Error,
  output logic [CNT_W-1:0] Period,
  output logic             Period_valid
);

  logic             w_s1;
  logic             w_rise;
  logic             w_fall;
  logic             w_valid;
  logic [1:0]       w_code;
  logic             w_timeout;
  logic [3:0]       w_cnt_inc;

  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_hi_meas;

  state_t           r_state,  w_state_n;
  logic [1:0]       r_cand,   w_cand_n;
  logic [3:0]       r_match,  w_match_n;
  logic [1:0]       r_sel,    w_sel_n;
  logic             r_locked, w_locked_n;
  logic             r_error,  w_error_n;
  logic [CNT_W-1:0] r_period, w_period_n;
  logic             r_pv,     w_pv_n;

  edge_sync u_edge_sync (
    .Clock    (Clock),
    .Reset    (Reset),
    .async_in (Clock_div),
    .sync_out (w_s1),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pcnt    <= '0;
      r_hcnt    <= '0;
      r_hi_meas <= '0;
    end else begin
      if (w_rise)
        r_pcnt <= CNT_W'(1);
      else if (r_pcnt != '1)
        r_pcnt <= r_pcnt + CNT_W'(1);

      if (w_rise)
        r_hcnt <= CNT_W'(1);
      else if (w_s1 && (r_hcnt != '1))
        r_hcnt <= r_hcnt + CNT_W'(1);

      if (w_fall)
        r_hi_meas <= r_hcnt;
    end
  end

  // Classification looks at pcnt before its reload, i.e. the period just completed.
  always_comb begin
    w_valid = 1'b0;
    w_code  = SEL_DIV2;
    if (r_pcnt == CNT_W'(PERIOD_DIV2)) begin
      w_code  = SEL_DIV2;
      w_valid = (r_hi_meas == CNT_W'(PERIOD_DIV2 / 2));
    end else if (r_pcnt == CNT_W'(PERIOD_DIV4)) begin
      w_code  = SEL_DIV4;
      w_valid = (r_hi_meas == CNT_W'(PERIOD_DIV4 / 2));
    end else if (r_pcnt == CNT_W'(PERIOD_DIV8)) begin
      w_code  = SEL_DIV8;
      w_valid = (r_hi_meas == CNT_W'(PERIOD_DIV8 / 2));
    end else if (r_pcnt == CNT_W'(PERIOD_DIV16)) begin
      w_code  = SEL_DIV16;
      w_valid = (r_hi_meas == CNT_W'(PERIOD_DIV16 / 2));
    end
  end

  assign w_timeout = (r_pcnt == CNT_W'(TIMEOUT));
  assign w_cnt_inc = r_match + 4'd1;

  always_comb begin
    w_state_n  = r_state;
    w_cand_n   = r_cand;
    w_match_n  = r_match;
    w_sel_n    = r_sel;
    w_locked_n = r_locked;
    w_error_n  = 1'b0;
    w_period_n = r_period;
    w_pv_n     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise)
          w_state_n = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_period_n = r_pcnt;
          w_pv_n     = 1'b1;
          if (w_valid) begin
            if (w_code == r_cand) begin
              w_match_n = w_cnt_inc;
            end else begin
              w_cand_n  = w_code;
              w_match_n = 4'd1;
            end
            if (w_match_n == 4'(LOCK_COUNT)) begin
              w_sel_n    = w_cand_n;
              w_locked_n = 1'b1;
              w_state_n  = ST_LOCKED;
            end
          end else begin
            w_match_n = '0;
          end
        end else if (w_timeout) begin
          w_state_n = ST_IDLE;
          w_match_n = '0;
        end
      end
      ST_LOCKED: begin
        if (w_rise) begin
          w_period_n = r_pcnt;
          w_pv_n     = 1'b1;
          if (!(w_valid && (w_code == r_sel))) begin
            w_locked_n = 1'b0;
            w_error_n  = 1'b1;
            w_state_n  = ST_MEASURE;
            if (w_valid) begin
              w_cand_n  = w_code;
              w_match_n = 4'd1;
            end else begin
              w_match_n = '0;
            end
          end
        end else if (w_timeout) begin
          w_state_n  = ST_IDLE;
          w_locked_n = 1'b0;
          w_error_n  = 1'b1;
          w_match_n  = '0;
        end
      end
      default: begin
        w_state_n  = ST_IDLE;
        w_locked_n = 1'b0;
        w_match_n  = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_match  <= '0;
      r_sel    <= '0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
      r_period <= '0;
      r_pv     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cand   <= w_cand_n;
      r_match  <= w_match_n;
      r_sel    <= w_sel_n;
      r_locked <= w_locked_n;
      r_error  <= w_error_n;
      r_period <= w_period_n;
      r_pv     <= w_pv_n;
    end
  end

  assign Sel_det      = r_sel;
  assign Locked       = r_locked;
  assign Error        = r_error;
  assign Period       = r_period;
  assign Period_valid = r_pv;

endmodule

// File: doc/clock_ratio_detector.md
Name: clock_ratio_detector

Overview:
- Receive-side companion to the programmable clock divider. It samples a divided clock in the fast system clock domain and measures its period and high time in system-clock cycles.
- It decodes which divide ratio (2/4/8/16) is present and reports it as a 2-bit select code with lock and error status.
- Used to check the divider output and to recover the divider setting at the far end of the clock path.

Parameters:
- CNT_W, 8, width of the period/high-time counters; counters saturate at 2^CNT_W-1.
- LOCK_COUNT, 4, consecutive identical valid periods required to assert Locked (range 1..15).
- TIMEOUT, 64, cycles without a rising edge before lock is dropped; must be greater than 16 and at most 2^CNT_W-1.

Ports:
- Clock, input, 1, system clock. All logic is on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- Clock_div, input, 1, divided clock under test; treated as asynchronous.
- Sel_det, output, 2, detected ratio: 00=/2, 01=/4, 10=/8, 11=/16.
- Locked, output, 1, high while the ratio is stable and matches Sel_det.
- Error, output, 1, one-cycle pulse on loss of lock (mismatch or timeout while Locked).
- Period, output, CNT_W, last measured period in Clock cycles.
- Period_valid, output, 1, one-cycle pulse when Period updates.

Behaviour:
- Reset: in any cycle with Reset=1, all registers clear at the next edge.
  - Sel_det=00, Locked=0, Error=0, Period=0, Period_valid=0.
  - Synchronizer flops=0, counters=0, match count=0, state=IDLE.
  - Reset mid-measurement discards all history.
- Input path:
  - 2-flop synchronizer s0→s1, plus a delay flop s2.
  - rise = s1 & ~s2; fall = ~s1 & s2.
  - An input edge reaches rise/fall two cycles after capture by s0.
- Period counter pcnt:
  - Loads 1 on a rise cycle; otherwise increments, saturating.
  - On a rise, the measured period is the value of pcnt before reload.
- High counter hcnt:
  - Loads 1 on a rise cycle; increments while s1=1 and no rise.
  - On a fall, its value is latched into hi_meas.
- Classification, evaluated at a rise (except the first after IDLE):
  - valid if period ∈ {2,4,8,16} and hi_meas == period/2.
  - code = log2(period)-1.
- Period reporting: Period and Period_valid update at every classified rise, valid or not.
- State machine, IDLE / MEASURE / LOCKED:
  - IDLE → MEASURE: on the first rise. No classification is made on this rise.
  - MEASURE, valid rise with code == candidate: match_cnt increments.
    - When match_cnt reaches LOCK_COUNT: Sel_det=candidate, Locked=1, go to LOCKED.
  - MEASURE, valid rise with a different code: candidate=code, match_cnt=1.
  - MEASURE, invalid rise: match_cnt=0.
  - LOCKED, valid rise with code == Sel_det: stay; no other change.
  - LOCKED, rise that is invalid or has a different code:
    - Locked=0, Error pulses for one cycle, go to MEASURE.
    - If the rise is valid, candidate=code and match_cnt=1; otherwise match_cnt=0.
  - Timeout: pcnt == TIMEOUT in MEASURE or LOCKED → IDLE, Locked=0, match_cnt=0.
    - Error pulses only if the state was LOCKED.
  - Sel_det holds its last locked value when lock is lost.
- Timing: all outputs are registered. Updates appear on the Clock edge that ends the rise (or timeout) cycle.
- Simultaneous events: a rise and a timeout cannot coincide because pcnt reloads on rise. Reset has priority over everything.

Decomposition:
- Shared package clkdiv_pkg, holding:
  - state encoding (IDLE/MEASURE/LOCKED);
  - select code constants SEL_DIV2..SEL_DIV16;
  - period constants 2/4/8/16, shared with the divider's Sel mapping.
- One sub-module, edge_sync:
  - ports Clock, Reset, async_in, sync_out, rise, fall;
  - implements the 2-flop synchronizer and the edge detector.

Test Plan:
- Clock_div toggling every Clock (period 2, high 1), LOCK_COUNT=4 → Period=2 on each Period_valid; Locked=1, Sel_det=00 after the 5th rise; Error never asserts.
- Period 16, high 8 → Sel_det=11, Locked=1 after the 4th matching classified rise; Period=16.
- Locked at /8, then switch to /4 → one Error pulse at the first 4-cycle rise; Locked=0; relock with Sel_det=01 after 3 more matching rises.
- Locked at /4, then hold Clock_div=0 → exactly 64 cycles after the last rise: Locked=0, Error pulses once, state IDLE; resume /4 → relock.
- Period 6 (high 3), or period 4 with high 1 → Period_valid pulses with Period=6 or 4; Locked stays 0; no Error.
- Reset asserted for 1 cycle mid-MEASURE after 2 matching /2 rises → all outputs 0 the next cycle; lock requires the full LOCK_COUNT matches again, counted from a new first rise.
